// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave register bank with read-back, frame-length
// checking and a one-cycle write strobe. Frame layout, MSB first:
// R/W (1 = write), ADDR_W address bits, then DATA_W data bits.
// Optional build macro SPI_REG_BANK_ERR_CNT_EN adds a saturating error
// counter. It is read through the top address and cleared by a write to it.
module spi_reg_bank #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SCLK,
  input  logic                       nCS,
  input  logic                       MOSI,
  output logic                       MISO,
  output logic                       miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr
`ifdef SPI_REG_BANK_ERR_CNT_EN
  ,
  output logic [7:0]                 err_cnt
`endif
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int HDR_W = 1 + ADDR_W;
  localparam int CNT_W = $clog2(FRAME + 2);
  localparam logic [CNT_W-1:0]  FRAME_C    = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0]  HDR_LAST_C = CNT_W'(ADDR_W);
  localparam logic [ADDR_W:0]   NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t              state_r;
  logic [2:0]          sclk_q;
  logic [2:0]          ncs_q;
  logic [1:0]          mosi_q;
  logic [CNT_W-1:0]    cnt_r;
  logic [HDR_W-1:0]    hdr_r;
  logic [DATA_W-1:0]   data_r;
  logic [DATA_W-1:0]   shadow_r;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic                sclk_rise;
  logic                sclk_fall;
  logic                ncs_rise;
  logic                ncs_fall;
  logic [HDR_W-1:0]    hdr_next;
  logic [DATA_W-1:0]   rd_data;
  logic                frame_wr;
  logic [ADDR_W-1:0]   frame_addr;
  logic                in_range;
  logic                exact_len;
  logic                clr_hit;
  logic                commit;
  logic                err_evt;

  // Synchronisers reset to idle pin levels so a frame open at reset release is never taken as complete
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 3'b000;
      ncs_q  <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], SCLK};
      ncs_q  <= {ncs_q[1:0], nCS};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
  assign ncs_fall  = ~ncs_q[1] & ncs_q[2];

  assign hdr_next   = HDR_W'({hdr_r, mosi_q[1]});
  assign frame_wr   = hdr_r[HDR_W-1];
  assign frame_addr = hdr_r[ADDR_W-1:0];
  assign in_range   = ({1'b0, frame_addr} < NUM_REGS_C);
  assign exact_len  = (state_r == DATA) && (cnt_r == FRAME_C);

`ifdef SPI_REG_BANK_ERR_CNT_EN
  localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};
  logic [39:0] err_ext;
  assign err_ext = {32'd0, err_cnt};
  assign clr_hit = (frame_addr == MAX_ADDR);
`else
  assign clr_hit = 1'b0;
`endif

  assign commit  = ncs_rise && exact_len && frame_wr && (in_range || clr_hit);
  // Short, overrun or out-of-range-write frames that actually clocked bits count as errors
  assign err_evt = ncs_rise && (state_r != IDLE) && (cnt_r != {CNT_W{1'b0}}) &&
                   ((state_r == ERR) || (cnt_r < FRAME_C) ||
                    (exact_len && frame_wr && !in_range && !clr_hit));

  // Read-back source for the address just completed in the header; unimplemented addresses read 0
  always_comb begin
    rd_data = {DATA_W{1'b0}};
    if ({1'b0, hdr_next[ADDR_W-1:0]} < NUM_REGS_C) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (hdr_next[ADDR_W-1:0] == ADDR_W'(i)) begin
          rd_data = regs[i];
        end else begin
          rd_data = rd_data;
        end
      end
    end else begin
      rd_data = {DATA_W{1'b0}};
    end
`ifdef SPI_REG_BANK_ERR_CNT_EN
    if (hdr_next[ADDR_W-1:0] == MAX_ADDR) begin
      rd_data = err_ext[DATA_W-1:0];
    end else begin
      rd_data = rd_data;
    end
`endif
  end

  // Frame FSM: header/data shifting, MISO drive and commit on nCS rise (nCS rise beats a same-cycle SCLK edge)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      hdr_r     <= {HDR_W{1'b0}};
      data_r    <= {DATA_W{1'b0}};
      shadow_r  <= {DATA_W{1'b0}};
      MISO      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= {ADDR_W{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= {DATA_W{1'b0}};
      end
    end else begin
      wr_strobe <= 1'b0;
      if (ncs_rise) begin
        state_r <= IDLE;
        MISO    <= 1'b0;
        miso_oe <= 1'b0;
        if (commit) begin
          wr_strobe <= 1'b1;
          wr_addr   <= frame_addr;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (in_range && (frame_addr == ADDR_W'(i))) begin
              regs[i] <= data_r;
            end
          end
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (ncs_fall) begin
              cnt_r   <= {CNT_W{1'b0}};
              hdr_r   <= {HDR_W{1'b0}};
              data_r  <= {DATA_W{1'b0}};
              state_r <= HDR;
            end
          end
          HDR: begin
            if (sclk_rise) begin
              hdr_r <= hdr_next;
              cnt_r <= cnt_r + CNT_W'(1);
              if (cnt_r == HDR_LAST_C) begin
                state_r <= DATA;
                if (!hdr_next[HDR_W-1]) begin
                  shadow_r <= rd_data;
                  miso_oe  <= 1'b1;
                end
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              data_r <= DATA_W'({data_r, mosi_q[1]});
              cnt_r  <= cnt_r + CNT_W'(1);
              if (cnt_r == FRAME_C) begin
                state_r <= ERR;
              end
            end else if (sclk_fall && !frame_wr) begin
              MISO     <= shadow_r[DATA_W-1];
              shadow_r <= shadow_r << 1;
            end
          end
          ERR: begin
            state_r <= ERR;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef SPI_REG_BANK_ERR_CNT_EN
  // Saturating error counter; a committed write to the top address clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (commit && clr_hit) begin
      err_cnt <= 8'd0;
    end else if (err_evt && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end
  endgenerate

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: a table of directed frames on a default instance,
// hand-written corner sequences, and a 16x16-bit / 4-bit-address instance.
module tb_spi_reg_bank;

  logic        clk;
  logic        rst;
  logic        sclk_v [2];
  logic        ncs_v  [2];
  logic        mosi_v [2];
  logic        miso_a, oe_a, strobe_a;
  logic        miso_b, oe_b, strobe_b;
  logic [39:0]  regs_flat_a;
  logic [255:0] regs_flat_b;
  logic [6:0]  wr_addr_a;
  logic [3:0]  wr_addr_b;
`ifdef SPI_REG_BANK_ERR_CNT_EN
  logic [7:0]  err_cnt_a, err_cnt_b;
`endif

  int total;
  int passed;
  int strb_a;
  int strb_b;

  spi_reg_bank #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7)) dut_a (
    .clk(clk), .rst(rst), .SCLK(sclk_v[0]), .nCS(ncs_v[0]), .MOSI(mosi_v[0]),
    .MISO(miso_a), .miso_oe(oe_a), .regs_flat(regs_flat_a),
    .wr_strobe(strobe_a), .wr_addr(wr_addr_a)
`ifdef SPI_REG_BANK_ERR_CNT_EN
    , .err_cnt(err_cnt_a)
`endif
  );

  spi_reg_bank #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4)) dut_b (
    .clk(clk), .rst(rst), .SCLK(sclk_v[1]), .nCS(ncs_v[1]), .MOSI(mosi_v[1]),
    .MISO(miso_b), .miso_oe(oe_b), .regs_flat(regs_flat_b),
    .wr_strobe(strobe_b), .wr_addr(wr_addr_b)
`ifdef SPI_REG_BANK_ERR_CNT_EN
    , .err_cnt(err_cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe pulse counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (strobe_a) strb_a++;
    if (strobe_b) strb_b++;
  end

  typedef struct {
    string       name;
    logic [31:0] frame;
    int          nbits;
    bit          is_read;
    logic [7:0]  exp_rd;
    int          exp_strb;
    logic [6:0]  exp_waddr;
    logic [39:0] exp_flat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // one SPI bit: present MOSI, sample MISO/oe just before the rising SCLK edge
  task automatic send_bit(input int sel, input logic b, input int half,
                          output logic m, output logic o);
    mosi_v[sel] = b;
    repeat (half) @(negedge clk);
    m = (sel == 0) ? miso_a : miso_b;
    o = (sel == 0) ? oe_a : oe_b;
    sclk_v[sel] = 1'b1;
    repeat (half) @(negedge clk);
    sclk_v[sel] = 1'b0;
  endtask

  task automatic spi_xfer(input int sel, input logic [63:0] frame, input int nbits,
                          input int half, input bit extra,
                          output logic [63:0] cap, output logic [63:0] oe_cap);
    logic m, o;
    cap = '0;
    oe_cap = '0;
    @(negedge clk);
    ncs_v[sel] = 1'b0;
    repeat (half) @(negedge clk);
    for (int k = nbits - 1; k >= 0; k--) begin
      send_bit(sel, frame[k], half, m, o);
      cap = {cap[62:0], m};
      oe_cap = {oe_cap[62:0], o};
    end
    repeat (half) @(negedge clk);
    ncs_v[sel] = 1'b1;
    if (extra) sclk_v[sel] = 1'b1;
    repeat (8) @(negedge clk);
    sclk_v[sel] = 1'b0;
    mosi_v[sel] = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  vec_t vecs [12];
  logic [63:0] cap, oecap;
  logic m, o;
  int s0;

  initial begin
    total = 0; passed = 0; strb_a = 0; strb_b = 0;
    for (int i = 0; i < 2; i++) begin
      sclk_v[i] = 1'b0; ncs_v[i] = 1'b1; mosi_v[i] = 1'b0;
    end

    vecs[0]  = '{"w0_a5",    32'h80A5,  16, 1'b0, 8'h00, 1, 7'd0, 40'h00_00_00_00_A5};
    vecs[1]  = '{"w4_3c",    32'h843C,  16, 1'b0, 8'h00, 1, 7'd4, 40'h3C_00_00_00_A5};
    vecs[2]  = '{"r4",       32'h0400,  16, 1'b1, 8'h3C, 0, 7'd4, 40'h3C_00_00_00_A5};
    vecs[3]  = '{"short15",  32'h40BB,  15, 1'b0, 8'h00, 0, 7'd4, 40'h3C_00_00_00_A5};
    vecs[4]  = '{"long17",   32'h102EE, 17, 1'b0, 8'h00, 0, 7'd4, 40'h3C_00_00_00_A5};
    vecs[5]  = '{"w9_oor",   32'h8955,  16, 1'b0, 8'h00, 0, 7'd4, 40'h3C_00_00_00_A5};
    vecs[6]  = '{"r9_oor",   32'h0900,  16, 1'b1, 8'h00, 0, 7'd4, 40'h3C_00_00_00_A5};
    vecs[7]  = '{"r0_dff",   32'h00FF,  16, 1'b1, 8'hA5, 0, 7'd4, 40'h3C_00_00_00_A5};
    vecs[8]  = '{"w3_5a",    32'h835A,  16, 1'b0, 8'h00, 1, 7'd3, 40'h3C_5A_00_00_A5};
    vecs[9]  = '{"w1_01",    32'h8101,  16, 1'b0, 8'h00, 1, 7'd1, 40'h3C_5A_00_01_A5};
    vecs[10] = '{"r3",       32'h0300,  16, 1'b1, 8'h5A, 0, 7'd1, 40'h3C_5A_00_01_A5};
    vecs[11] = '{"w0_00",    32'h8000,  16, 1'b0, 8'h00, 1, 7'd0, 40'h3C_5A_00_01_00};

    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_flat_a", 64'(regs_flat_a), 64'd0);
    check("rst_miso_a", 64'(miso_a), 64'd0);
    check("rst_oe_a", 64'(oe_a), 64'd0);
    check("rst_waddr_a", 64'(wr_addr_a), 64'd0);
    check("rst_strobe_a", 64'(strobe_a), 64'd0);
    check("rst_flat_b", 64'(|regs_flat_b), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      s0 = strb_a;
      spi_xfer(0, {32'd0, vecs[v].frame}, vecs[v].nbits, 4, 1'b0, cap, oecap);
      check({vecs[v].name, "_flat"}, 64'(regs_flat_a), 64'(vecs[v].exp_flat));
      check({vecs[v].name, "_strobes"}, 64'(strb_a - s0), 64'(vecs[v].exp_strb));
      check({vecs[v].name, "_waddr"}, 64'(wr_addr_a), 64'(vecs[v].exp_waddr));
      check({vecs[v].name, "_idle_out"}, 64'({miso_a, oe_a}), 64'd0);
      if (vecs[v].is_read) begin
        check({vecs[v].name, "_rdata"}, 64'(cap[7:0]), 64'(vecs[v].exp_rd));
        check({vecs[v].name, "_oe"}, 64'(oecap[15:0]), 64'h00FF);
      end else begin
        check({vecs[v].name, "_oe"}, oecap, 64'd0);
      end
    end
`ifdef SPI_REG_BANK_ERR_CNT_EN
    check("err_cnt_after_table", 64'(err_cnt_a), 64'd3);
`endif

    // reset in the middle of a write to reg2 = 0xFF, frame finished after release
    s0 = strb_a;
    @(negedge clk);
    ncs_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 15; k >= 6; k--) begin
      cap[0] = 1'b0;
      send_bit(0, 1'(32'h82FF >> k), 4, m, o);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_flat", 64'(regs_flat_a), 64'd0);
    check("midrst_waddr", 64'(wr_addr_a), 64'd0);
    check("midrst_oe", 64'(oe_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 5; k >= 0; k--) begin
      send_bit(0, 1'(32'h82FF >> k), 4, m, o);
    end
    repeat (4) @(negedge clk);
    ncs_v[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_after_flat", 64'(regs_flat_a), 64'd0);
    check("midrst_after_strobes", 64'(strb_a - s0), 64'd0);

    s0 = strb_a;
    spi_xfer(0, 64'h8211, 16, 4, 1'b0, cap, oecap);
    check("w2_11_flat", 64'(regs_flat_a), 64'h00_00_11_00_00);
    check("w2_11_waddr", 64'(wr_addr_a), 64'd2);
    check("w2_11_strobes", 64'(strb_a - s0), 64'd1);

    // SCLK activity while deselected must not disturb the next frame
    for (int t = 0; t < 5; t++) begin
      sclk_v[0] = 1'b1; mosi_v[0] = 1'b1;
      repeat (4) @(negedge clk);
      sclk_v[0] = 1'b0;
      repeat (4) @(negedge clk);
    end
    spi_xfer(0, 64'h8122, 16, 4, 1'b0, cap, oecap);
    check("ncs_hi_sclk_flat", 64'(regs_flat_a), 64'h00_00_11_22_00);
    check("ncs_hi_sclk_waddr", 64'(wr_addr_a), 64'd1);

    // extra SCLK rise coinciding with nCS rise is not counted: the frame commits
    s0 = strb_a;
    spi_xfer(0, 64'h8477, 16, 4, 1'b1, cap, oecap);
    check("simul_flat", 64'(regs_flat_a), 64'h77_00_11_22_00);
    check("simul_strobes", 64'(strb_a - s0), 64'd1);
    check("simul_waddr", 64'(wr_addr_a), 64'd4);

    // wide instance, SCLK = clk/8
    s0 = strb_b;
    spi_xfer(1, 64'h1FBEEF, 21, 4, 1'b0, cap, oecap);
    check("b_w15_reg", 64'(regs_flat_b[255:240]), 64'hBEEF);
    check("b_w15_rest", 64'(|regs_flat_b[239:0]), 64'd0);
    check("b_w15_waddr", 64'(wr_addr_b), 64'd15);
    check("b_w15_strobes", 64'(strb_b - s0), 64'd1);
    spi_xfer(1, 64'h0F0000, 21, 4, 1'b0, cap, oecap);
    check("b_r15_rdata", 64'(cap[15:0]), 64'hBEEF);
    check("b_r15_oe", 64'(oecap[20:0]), 64'h00FFFF);

    // wide instance, SCLK = clk/20
    spi_xfer(1, 64'h17BEEF, 21, 10, 1'b0, cap, oecap);
    check("b_w7_reg", 64'(regs_flat_b[127:112]), 64'hBEEF);
    check("b_w7_waddr", 64'(wr_addr_b), 64'd7);
    spi_xfer(1, 64'h070000, 21, 10, 1'b0, cap, oecap);
    check("b_r7_rdata", 64'(cap[15:0]), 64'hBEEF);
    check("b_r7_oe", 64'(oecap[20:0]), 64'h00FFFF);
    check("b_idle_out", 64'({miso_b, oe_b}), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
